coherent_l1_cache: RTL and testbench

Parametrised direct-mapped, write-through L1 data cache for one core of the multi-core CPU. It sits between the core's memory stage and the shared SSRAM port. It generalises the fixed 6-bit, three-peer cache with configurable depth, width, peer count and SRAM latency. It adds a proper miss/write FSM, peer write-invalidation with defined priority, and per-peer snoop read ports.

---
 rtl/coherent_l1_cache.sv | 241 ++++++++++++++++++++++++
 tb/tb_coherent_l1_cache.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/coherent_l1_cache.sv
// coherent_l1_cache
// Direct-mapped, write-through L1 data cache with one word per line, for one
// core of a multi-core CPU. It sits between the core memory stage and the
// shared SSRAM port.
//   new_clock, reset_n     : clock and synchronous active-low reset
//   req_*                  : core request (held while stall=1)
//   rdata, stall           : load data and pipeline stall (combinational)
//   sram_*                 : SSRAM port (address/data/strobes, read data in)
//   bcast_valid/addr       : own-store broadcast to peers
//   peer_inv_valid/addr    : peer store broadcasts, which invalidate matching lines
//   snoop_addr/data/hit    : per-peer combinational read ports into the array
// Optional feature macro PERF_COUNTERS_EN adds the saturating hit_count and
// miss_count outputs.
module coherent_l1_cache #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 6,
    parameter int INDEX_W   = 4,
    parameter int NUM_PEERS = 3,
    parameter int SRAM_LAT  = 2
) (
    input  logic                          new_clock,
    input  logic                          reset_n,
    input  logic                          req_en,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          stall,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [DATA_W-1:0]             sram_wdata,
    output logic                          sram_we,
    output logic                          sram_oe,
    input  logic [DATA_W-1:0]             sram_rdata,
    output logic                          bcast_valid,
    output logic [ADDR_W-1:0]             bcast_addr,
    input  logic [NUM_PEERS-1:0]          peer_inv_valid,
    input  logic [NUM_PEERS*ADDR_W-1:0]   peer_inv_addr,
    input  logic [NUM_PEERS*ADDR_W-1:0]   snoop_addr,
    output logic [NUM_PEERS*DATA_W-1:0]   snoop_data,
    output logic [NUM_PEERS-1:0]          snoop_hit
`ifdef PERF_COUNTERS_EN
    ,
    output logic [15:0]                   hit_count,
    output logic [15:0]                   miss_count
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int CNT_W = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  resp_data_r;
    logic [LINES-1:0]   valid_r;
    logic [TAG_W-1:0]   tag_r  [LINES];
    logic [DATA_W-1:0]  data_r [LINES];

    logic [INDEX_W-1:0] idx_s;
    logic [INDEX_W-1:0] fill_idx_s;
    logic               hit_s;
    logic               store_s;
    logic               load_hit_s;
    logic               load_miss_s;
    logic               fill_s;
    logic [NUM_PEERS-1:0] kill_s;

    assign idx_s       = req_addr[INDEX_W-1:0];
    assign fill_idx_s  = addr_r[INDEX_W-1:0];
    assign hit_s       = valid_r[idx_s] && (tag_r[idx_s] == req_addr[ADDR_W-1:INDEX_W]);
    assign store_s     = (state_r == IDLE) && req_en && req_we;
    assign load_hit_s  = (state_r == IDLE) && req_en && !req_we && hit_s;
    assign load_miss_s = (state_r == IDLE) && req_en && !req_we && !hit_s;
    assign fill_s      = (state_r == RD_WAIT) && (cnt_r == CNT_W'(0));

    // Per-peer invalidate decision. On the line being filled this cycle the
    // peer address is compared with the incoming fill, so invalidate beats fill.
    always_comb begin
        kill_s = '0;
        for (int i = 0; i < NUM_PEERS; i++) begin
            if (peer_inv_valid[i]) begin
                if (fill_s && (peer_inv_addr[i*ADDR_W +: INDEX_W] == fill_idx_s)) begin
                    kill_s[i] = (peer_inv_addr[i*ADDR_W +: ADDR_W] == addr_r);
                end else begin
                    kill_s[i] = valid_r[peer_inv_addr[i*ADDR_W +: INDEX_W]] &&
                                (tag_r[peer_inv_addr[i*ADDR_W +: INDEX_W]] ==
                                 peer_inv_addr[i*ADDR_W+INDEX_W +: TAG_W]);
                end
            end else begin
                kill_s[i] = 1'b0;
            end
        end
    end

    // Core-side and SSRAM-side outputs decoded from state and live request.
    always_comb begin
        stall       = 1'b0;
        rdata       = data_r[idx_s];
        sram_addr   = req_addr;
        sram_wdata  = req_wdata;
        sram_we     = 1'b0;
        sram_oe     = 1'b0;
        bcast_valid = 1'b0;
        bcast_addr  = req_addr;
        case (state_r)
            IDLE: begin
                if (req_en && req_we) begin
                    stall       = 1'b1;
                    sram_we     = 1'b1;
                    bcast_valid = 1'b1;
                end else if (req_en && !hit_s) begin
                    stall   = 1'b1;
                    sram_oe = 1'b1;
                end else begin
                    stall = 1'b0;
                end
            end
            RD_WAIT: begin
                stall     = 1'b1;
                sram_oe   = 1'b1;
                sram_addr = addr_r;
            end
            WR_WAIT: begin
                stall     = 1'b1;
                sram_addr = addr_r;
            end
            RESP: begin
                // Registered fill value: still correct if the line was invalidated.
                rdata     = resp_data_r;
                sram_addr = addr_r;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Miss/write sequencing FSM with latency counter and held address.
    always_ff @(posedge new_clock) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            addr_r      <= '0;
            resp_data_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (store_s) begin
                        addr_r  <= req_addr;
                        cnt_r   <= CNT_W'(SRAM_LAT - 1);
                        state_r <= WR_WAIT;
                    end else if (load_miss_s) begin
                        addr_r  <= req_addr;
                        cnt_r   <= CNT_W'(SRAM_LAT - 1);
                        state_r <= RD_WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (cnt_r == CNT_W'(0)) begin
                        resp_data_r <= sram_rdata;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (cnt_r == CNT_W'(0)) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                RESP:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Valid bits: set by fill, cleared by peer invalidates (applied last so they win).
    always_ff @(posedge new_clock) begin
        if (!reset_n) begin
            valid_r <= '0;
        end else begin
            if (fill_s) begin
                valid_r[fill_idx_s] <= 1'b1;
            end
            for (int i = 0; i < NUM_PEERS; i++) begin
                if (kill_s[i]) begin
                    valid_r[peer_inv_addr[i*ADDR_W +: INDEX_W]] <= 1'b0;
                end
            end
        end
    end

    // Line data and tags; write-no-allocate, so stores only touch hitting lines.
    always_ff @(posedge new_clock) begin
        if (reset_n) begin
            if (fill_s) begin
                data_r[fill_idx_s] <= sram_rdata;
                tag_r[fill_idx_s]  <= addr_r[ADDR_W-1:INDEX_W];
            end else if (store_s && hit_s) begin
                data_r[idx_s] <= req_wdata;
            end
        end
    end

    // Snoop read ports straight off the array, independent of the FSM.
    always_comb begin
        snoop_data = '0;
        snoop_hit  = '0;
        for (int i = 0; i < NUM_PEERS; i++) begin
            snoop_data[i*DATA_W +: DATA_W] = data_r[snoop_addr[i*ADDR_W +: INDEX_W]];
            snoop_hit[i] = valid_r[snoop_addr[i*ADDR_W +: INDEX_W]] &&
                           (tag_r[snoop_addr[i*ADDR_W +: INDEX_W]] ==
                            snoop_addr[i*ADDR_W+INDEX_W +: TAG_W]);
        end
    end

`ifdef PERF_COUNTERS_EN
    // Saturating hit/miss counters for IDLE load lookups.
    always_ff @(posedge new_clock) begin
        if (!reset_n) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else begin
            if (load_hit_s && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'h0001;
            end
            if (load_miss_s && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_coherent_l1_cache.sv
// Self-checking bench for coherent_l1_cache (default parameters). Expected
// results are queued when a request is driven and compared when it retires.
module tb_coherent_l1_cache;

    logic        new_clock = 1'b0;
    logic        reset_n   = 1'b0;
    logic        req_en    = 1'b0;
    logic        req_we    = 1'b0;
    logic [5:0]  req_addr  = 6'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic [5:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_we;
    logic        sram_oe;
    logic [31:0] sram_rdata;
    logic        bcast_valid;
    logic [5:0]  bcast_addr;
    logic [2:0]  peer_inv_valid = 3'b000;
    logic [17:0] peer_inv_addr  = 18'd0;
    logic [17:0] snoop_addr     = 18'd0;
    logic [95:0] snoop_data;
    logic [2:0]  snoop_hit;
`ifdef PERF_COUNTERS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    coherent_l1_cache dut (
        .new_clock(new_clock), .reset_n(reset_n),
        .req_en(req_en), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .stall(stall),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
        .sram_oe(sram_oe), .sram_rdata(sram_rdata),
        .bcast_valid(bcast_valid), .bcast_addr(bcast_addr),
        .peer_inv_valid(peer_inv_valid), .peer_inv_addr(peer_inv_addr),
        .snoop_addr(snoop_addr), .snoop_data(snoop_data), .snoop_hit(snoop_hit)
`ifdef PERF_COUNTERS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 new_clock = ~new_clock;

    // SSRAM model: combinational read, write on the clock edge.
    logic [31:0] mem [64];
    assign sram_rdata = mem[sram_addr];

    int          we_cnt = 0;
    int          bc_cnt = 0;
    logic [5:0]  last_we_addr = 6'd0;
    logic [31:0] last_we_data = 32'd0;
    logic [5:0]  last_bc_addr = 6'd0;

    always @(posedge new_clock) begin
        if (sram_we) begin
            mem[sram_addr] <= sram_wdata;
            we_cnt         <= we_cnt + 1;
            last_we_addr   <= sram_addr;
            last_we_data   <= sram_wdata;
        end
        if (bcast_valid) begin
            bc_cnt       <= bc_cnt + 1;
            last_bc_addr <= bcast_addr;
        end
    end

    typedef struct {
        string       tag;
        int          stalls;
        logic [31:0] data;
        logic        is_load;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Optional stimulus side-channels used inside do_req's stall loop.
    int          inv_at    = -1;
    logic [2:0]  inv_mask  = 3'b000;
    logic [17:0] inv_addrs = 18'd0;
    logic        snoop_chk = 1'b0;
    logic [31:0] snoop_exp = 32'd0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one request, count stall cycles, then compare against the queue head.
    task automatic do_req(input string tag, input logic we, input logic [5:0] addr,
                          input logic [31:0] wdata, input int exp_stalls,
                          input logic [31:0] exp_data);
        exp_t e;
        int   stalls;
        int   we0;
        int   bc0;
        e.tag = tag; e.stalls = exp_stalls; e.data = exp_data; e.is_load = !we;
        exp_q.push_back(e);
        we0 = we_cnt;
        bc0 = bc_cnt;
        @(negedge new_clock);
        req_en = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        #1;
        stalls = 0;
        while (stall === 1'b1 && stalls < 40) begin
            stalls++;
            if (snoop_chk) begin
                check_eq({tag, "_snoop_hit"}, 64'(snoop_hit), 64'(3'b100));
                check_eq({tag, "_snoop_data"}, 64'(snoop_data[64 +: 32]), 64'(snoop_exp));
            end
            if (stalls == inv_at) begin
                peer_inv_valid = inv_mask; peer_inv_addr = inv_addrs;
            end else begin
                peer_inv_valid = 3'b000;
            end
            @(negedge new_clock);
            #1;
        end
        peer_inv_valid = 3'b000;
        e = exp_q.pop_front();
        check_eq({e.tag, "_stalls"}, 64'(stalls), 64'(e.stalls));
        if (e.is_load) begin
            check_eq({e.tag, "_rdata"}, 64'(rdata), 64'(e.data));
        end
        @(negedge new_clock);
        req_en = 1'b0; req_we = 1'b0;
        #1;
        check_eq({e.tag, "_we_pulses"}, 64'(we_cnt - we0), 64'(we ? 1 : 0));
        check_eq({e.tag, "_bcast_pulses"}, 64'(bc_cnt - bc0), 64'(we ? 1 : 0));
        if (we) begin
            check_eq({e.tag, "_we_addr"}, 64'(last_we_addr), 64'(addr));
            check_eq({e.tag, "_we_data"}, 64'(last_we_data), 64'(wdata));
            check_eq({e.tag, "_bcast_addr"}, 64'(last_bc_addr), 64'(addr));
        end
    endtask

    // One-cycle peer invalidate while the cache is idle.
    task automatic peer_inv(input logic [2:0] mask, input logic [17:0] addrs);
        @(negedge new_clock);
        peer_inv_valid = mask; peer_inv_addr = addrs;
        @(negedge new_clock);
        peer_inv_valid = 3'b000;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[5] = 32'hDEADBEEF;

        // Reset state.
        repeat (3) @(negedge new_clock);
        reset_n = 1'b1;
        #1;
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_oe", 64'(sram_oe), 64'd0);
        check_eq("rst_we", 64'(sram_we), 64'd0);
        check_eq("rst_bcast", 64'(bcast_valid), 64'd0);
        snoop_addr = {6'h05, 6'h05, 6'h05};
        #1;
        check_eq("rst_snoop_hit", 64'(snoop_hit), 64'd0);
`ifdef PERF_COUNTERS_EN
        check_eq("rst_hit_count", 64'(hit_count), 64'd0);
        check_eq("rst_miss_count", 64'(miss_count), 64'd0);
`endif

        // Miss fill, then zero-latency hit.
        do_req("ld_miss", 1'b0, 6'h05, 32'd0, 3, 32'hDEADBEEF);
        do_req("ld_hit", 1'b0, 6'h05, 32'd0, 0, 32'hDEADBEEF);
`ifdef PERF_COUNTERS_EN
        check_eq("hit_count", 64'(hit_count), 64'd1);
        check_eq("miss_count", 64'(miss_count), 64'd1);
`endif

        // Store hit updates line and SSRAM.
        do_req("st_hit", 1'b1, 6'h05, 32'hCAFEF00D, 3, 32'd0);
        do_req("ld_after_st", 1'b0, 6'h05, 32'd0, 0, 32'hCAFEF00D);

        // Invalidate same index, other tag: line survives.
        peer_inv(3'b010, {6'h00, 6'h15, 6'h00});
        do_req("ld_other_tag_inv", 1'b0, 6'h05, 32'd0, 0, 32'hCAFEF00D);

        // Matching invalidate from peer1: next load misses.
        peer_inv(3'b010, {6'h00, 6'h05, 6'h00});
        do_req("ld_after_inv", 1'b0, 6'h05, 32'd0, 3, 32'hCAFEF00D);

        // Store-miss does not allocate; line 0x05 keeps its data.
        do_req("st_5", 1'b1, 6'h05, 32'h12345678, 3, 32'd0);
        do_req("st_miss", 1'b1, 6'h25, 32'h0BADF00D, 3, 32'd0);
        do_req("ld_after_st_miss", 1'b0, 6'h05, 32'd0, 0, 32'h12345678);

        // Snoop from peer2 while a store waits on SSRAM.
        snoop_addr = {6'h05, 6'h15, 6'h0A};
        #1;
        check_eq("snoop_idle_hit", 64'(snoop_hit), 64'(3'b100));
        check_eq("snoop_idle_data", 64'(snoop_data[64 +: 32]), 64'h12345678);
        snoop_chk = 1'b1; snoop_exp = 32'h12345678;
        do_req("st_snoop", 1'b1, 6'h0A, 32'h0000_00AA, 3, 32'd0);
        snoop_chk = 1'b0;

        // Invalidate colliding with the fill: RESP returns SSRAM data, line stays invalid.
        peer_inv(3'b001, {6'h00, 6'h00, 6'h05});
        @(negedge new_clock);
        mem[5] = 32'hA5A50005;
        inv_at = 3; inv_mask = 3'b001; inv_addrs = {6'h00, 6'h00, 6'h05};
        do_req("ld_fill_inv", 1'b0, 6'h05, 32'd0, 3, 32'hA5A50005);
        inv_at = -1;
        do_req("ld_refill", 1'b0, 6'h05, 32'd0, 3, 32'hA5A50005);

        // Reset in the middle of RD_WAIT.
        mem[6'h33] = 32'h33333333;
        @(negedge new_clock);
        req_en = 1'b1; req_we = 1'b0; req_addr = 6'h33;
        @(negedge new_clock);
        reset_n = 1'b0; req_en = 1'b0;
        @(negedge new_clock);
        #1;
        check_eq("midrst_stall", 64'(stall), 64'd0);
        check_eq("midrst_oe", 64'(sram_oe), 64'd0);
        check_eq("midrst_snoop_hit", 64'(snoop_hit), 64'd0);
`ifdef PERF_COUNTERS_EN
        check_eq("midrst_hit_count", 64'(hit_count), 64'd0);
        check_eq("midrst_miss_count", 64'(miss_count), 64'd0);
`endif
        reset_n = 1'b1;
        do_req("ld_post_rst", 1'b0, 6'h05, 32'd0, 3, 32'hA5A50005);
        do_req("ld_post_rst_33", 1'b0, 6'h33, 32'd0, 3, 32'h33333333);

        repeat (2) @(negedge new_clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
